enet_pll_seq: RTL and testbench

Sequencer for the Ethernet PLL (50 MHz ref → 125/25/2.5 MHz) and the MAC transmit-clock selection. It runs on the 50 MHz reference clock.
- It holds the PLL in reset for a fixed interval, then waits for a debounced lock.
- It monitors for loss of lock.
- It performs glitch-safe switching of the MAC clock mux between 1000/100/10 Mbps when the PHY-negotiated speed changes.
- It sits between the PLL instance, the clock mux/gate cells and the MAC/PHY management logic.

---
 rtl/enet_pll_seq.sv | 213 +++++++++++++++++++++
 tb/tb_enet_pll_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/enet_pll_seq.sv
// Ethernet PLL power-up/lock sequencer and glitch-safe MAC clock mux control.
// Optional macro ENET_PLL_SEQ_RETRY_EN: lock timeout retries instead of sticking in FAULT.
//
// state       | meaning
// RESET_PLL   | pll_rst held high for RST_CYCLES
// WAIT_LOCK   | pll_rst released, waiting for synchronized lock (timeout guarded)
// STABLE      | counting consecutive locked cycles, then latch clk_sel
// GATE_ON     | clock gate held off for QUIET_CYCLES before enabling
// RUN         | clock running, ready high, watching lock and speed_req
// GATE_OFF    | clock gate off, settling QUIET_CYCLES before the mux moves
// SWITCH      | mux select updated from speed_req
// FAULT       | lock timeout, PLL held in reset until rst
module enet_pll_seq #(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_STABLE  = 1024,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int QUIET_CYCLES = 8
) (
   input  logic       refclk_i,
   input  logic       rst_i,
   input  logic       pll_locked_i,
   input  logic [1:0] speed_req_i,
   output logic       pll_rst_o,
   output logic [1:0] clk_sel_o,
   output logic       clk_en_o,
   output logic       ready_o,
   output logic       speed_ack_o,
   output logic       fault_o,
   output logic [7:0] retry_cnt_o
);

   localparam int MAX_A = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
   localparam int MAX_B = (LOCK_TIMEOUT > QUIET_CYCLES) ? LOCK_TIMEOUT : QUIET_CYCLES;
   localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = $clog2(MAX_P + 1);

   localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] Q_LAST   = CW'(QUIET_CYCLES - 1);

   typedef enum logic [2:0] {
      S_RESET_PLL,
      S_WAIT_LOCK,
      S_STABLE,
      S_GATE_ON,
      S_RUN,
      S_GATE_OFF,
      S_SWITCH,
      S_FAULT
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic            lk_meta_q;
   logic            lk_s_q;
   logic            from_sw_q;
   logic            pll_rst_q;
   logic [1:0]      clk_sel_q;
   logic            clk_en_q;
   logic            ready_q;
   logic            speed_ack_q;
   logic            fault_q;
   logic [7:0]      retry_q;
   logic [1:0]      sel_cold_d;
   logic [1:0]      sel_hold_d;
   logic            req_valid;
   logic            lost_lock;

   assign cnt_d      = cnt_q + 1'b1;
   assign req_valid  = (speed_req_i != 2'b11);
   assign sel_cold_d = req_valid ? speed_req_i : 2'b10;
   assign sel_hold_d = req_valid ? speed_req_i : clk_sel_q;

   // Loss of lock only aborts the states where the MAC clock path is being driven.
   assign lost_lock = !lk_s_q && ((state_q == S_GATE_ON) || (state_q == S_RUN) ||
                                  (state_q == S_GATE_OFF) || (state_q == S_SWITCH));

   always_ff @(posedge refclk_i) begin
      if (rst_i) begin
         state_q     <= S_RESET_PLL;
         cnt_q       <= '0;
         lk_meta_q   <= 1'b0;
         lk_s_q      <= 1'b0;
         from_sw_q   <= 1'b0;
         pll_rst_q   <= 1'b1;
         clk_sel_q   <= 2'b10;
         clk_en_q    <= 1'b0;
         ready_q     <= 1'b0;
         speed_ack_q <= 1'b0;
         fault_q     <= 1'b0;
         retry_q     <= 8'd0;
      end else begin
         lk_meta_q   <= pll_locked_i;
         lk_s_q      <= lk_meta_q;
         speed_ack_q <= 1'b0;
`ifdef ENET_PLL_SEQ_RETRY_EN
         fault_q     <= 1'b0;
`endif
         if (lost_lock) begin
            state_q   <= S_RESET_PLL;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            clk_en_q  <= 1'b0;
            ready_q   <= 1'b0;
         end else begin
            case (state_q)
               S_RESET_PLL: begin
                  pll_rst_q <= 1'b1;
                  clk_en_q  <= 1'b0;
                  ready_q   <= 1'b0;
                  if (cnt_q == RST_LAST) begin
                     state_q   <= S_WAIT_LOCK;
                     cnt_q     <= '0;
                     pll_rst_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
               S_WAIT_LOCK: begin
                  if (lk_s_q) begin
                     state_q <= S_STABLE;
                     cnt_q   <= '0;
                  end else if (cnt_q == TO_LAST) begin
                     if (retry_q != 8'hFF) begin
                        retry_q <= retry_q + 8'd1;
                     end
                     cnt_q     <= '0;
                     pll_rst_q <= 1'b1;
                     fault_q   <= 1'b1;
`ifdef ENET_PLL_SEQ_RETRY_EN
                     state_q   <= S_RESET_PLL;
`else
                     state_q   <= S_FAULT;
`endif
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
               S_STABLE: begin
                  if (!lk_s_q) begin
                     state_q <= S_WAIT_LOCK;
                     cnt_q   <= '0;
                  end else if (cnt_q == STB_LAST) begin
                     clk_sel_q <= sel_cold_d;
                     from_sw_q <= 1'b0;
                     state_q   <= S_GATE_ON;
                     cnt_q     <= '0;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
               S_GATE_ON: begin
                  if (cnt_q == Q_LAST) begin
                     state_q     <= S_RUN;
                     cnt_q       <= '0;
                     clk_en_q    <= 1'b1;
                     ready_q     <= 1'b1;
                     speed_ack_q <= from_sw_q;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
               S_RUN: begin
                  if (req_valid && (speed_req_i != clk_sel_q)) begin
                     state_q  <= S_GATE_OFF;
                     cnt_q    <= '0;
                     clk_en_q <= 1'b0;
                     ready_q  <= 1'b0;
                  end
               end
               S_GATE_OFF: begin
                  if (cnt_q == Q_LAST) begin
                     state_q <= S_SWITCH;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
               S_SWITCH: begin
                  clk_sel_q <= sel_hold_d;
                  from_sw_q <= 1'b1;
                  state_q   <= S_GATE_ON;
                  cnt_q     <= '0;
               end
               S_FAULT: begin
                  pll_rst_q <= 1'b1;
                  fault_q   <= 1'b1;
                  clk_en_q  <= 1'b0;
                  ready_q   <= 1'b0;
               end
               default: begin
                  state_q   <= S_RESET_PLL;
                  cnt_q     <= '0;
                  pll_rst_q <= 1'b1;
                  clk_en_q  <= 1'b0;
                  ready_q   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign pll_rst_o   = pll_rst_q;
   assign clk_sel_o   = clk_sel_q;
   assign clk_en_o    = clk_en_q;
   assign ready_o     = ready_q;
   assign speed_ack_o = speed_ack_q;
   assign fault_o     = fault_q;
   assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_enet_pll_seq.sv
// Self-checking bench for enet_pll_seq: randomized lock/speed stimulus against
// edge-time expectations derived from the sequencing rules.
module tb_enet_pll_seq;

   localparam int RST = 16;
   localparam int LS  = 1024;
   localparam int LT  = 256;
   localparam int Q   = 8;

   logic       refclk_i     = 1'b0;
   logic       rst_i        = 1'b1;
   logic       pll_locked_i = 1'b0;
   logic [1:0] speed_req_i  = 2'b10;
   logic       pll_rst_o;
   logic [1:0] clk_sel_o;
   logic       clk_en_o;
   logic       ready_o;
   logic       speed_ack_o;
   logic       fault_o;
   logic [7:0] retry_cnt_o;

   int cyc;
   int ack_cnt;
   int n_tests;
   int n_fail;

   enet_pll_seq #(
      .RST_CYCLES  (RST),
      .LOCK_STABLE (LS),
      .LOCK_TIMEOUT(LT),
      .QUIET_CYCLES(Q)
   ) dut (
      .refclk_i    (refclk_i),
      .rst_i       (rst_i),
      .pll_locked_i(pll_locked_i),
      .speed_req_i (speed_req_i),
      .pll_rst_o   (pll_rst_o),
      .clk_sel_o   (clk_sel_o),
      .clk_en_o    (clk_en_o),
      .ready_o     (ready_o),
      .speed_ack_o (speed_ack_o),
      .fault_o     (fault_o),
      .retry_cnt_o (retry_cnt_o)
   );

   always #10 refclk_i = ~refclk_i;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Every time step goes through here: sample #1 after the edge, count ack pulses.
   task automatic tick();
      @(posedge refclk_i);
      #1;
      cyc++;
      if (speed_ack_o) ack_cnt++;
   endtask

   task automatic tick_to(input int target);
      while (cyc < target) tick();
   endtask

   function automatic logic pick(input int which);
      case (which)
         0:       pick = ready_o;
         1:       pick = pll_rst_o;
         2:       pick = clk_en_o;
         3:       pick = fault_o;
         default: pick = 1'b0;
      endcase
   endfunction

   task automatic wait_until(input int which, input logic lvl, input int budget, output int edge_at);
      edge_at = -1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (pick(which) === lvl) begin
            edge_at = cyc;
            break;
         end
      end
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_pll_rst"},   int'(pll_rst_o),   1);
      chk({tag, "_clk_sel"},   int'(clk_sel_o),   2);
      chk({tag, "_clk_en"},    int'(clk_en_o),    0);
      chk({tag, "_ready"},     int'(ready_o),     0);
      chk({tag, "_speed_ack"}, int'(speed_ack_o), 0);
      chk({tag, "_fault"},     int'(fault_o),     0);
      chk({tag, "_retry_cnt"}, int'(retry_cnt_o), 0);
   endtask

   initial begin
      int e, ack0, model_sel, tgt, tgt2, fin, old, s0, redirect, rchg;
      int fall, sel_e, rise, ack_at_rise, d, k, big_e, g, en_low;
      n_tests = 0;
      n_fail  = 0;
      ack_cnt = 0;
      cyc     = 0;

      // Power-on reset, then cold start with lock 100 cycles after pll_rst falls.
      rst_i = 1'b1;
      repeat (3) tick();
      check_reset_outs("por");
      rst_i = 1'b0;
      cyc   = 0;
      ack0  = ack_cnt;
      wait_until(1, 1'b0, RST + 5, e);
      chk("cold_pll_rst_fall", e, RST);
      tick_to(RST + 100);
      pll_locked_i = 1'b1;
      wait_until(0, 1'b1, LS + Q + 150, e);
      chk("cold_ready_edge", e, RST + 100 + 2 + LS + Q + 1);
      chk("cold_clk_sel", int'(clk_sel_o), 2);
      chk("cold_clk_en", int'(clk_en_o), 1);
      chk("cold_no_ack", ack_cnt - ack0, 0);
      model_sel = 2;

      // Random speed switches, some redirected mid GATE_OFF (last value sampled wins).
      for (int n = 0; n < 6; n++) begin
         repeat ($urandom_range(2, 20)) tick();
         chk("sw_ready_idle", int'(ready_o), 1);
         tgt      = (n == 0) ? 1 : (model_sel + int'($urandom_range(1, 2))) % 3;
         tgt2     = 3 - model_sel - tgt;
         redirect = (n == 0) ? 0 : int'($urandom_range(0, 1));
         rchg     = int'($urandom_range(1, Q - 1));
         fin      = redirect ? tgt2 : tgt;
         old      = model_sel;
         ack0     = ack_cnt;
         s0       = cyc + 1;
         speed_req_i = 2'(tgt);
         fall = -1; sel_e = -1; rise = -1; ack_at_rise = 0;
         for (int i = 0; i < 4 * Q + 10; i++) begin
            tick();
            if (redirect && cyc == s0 + rchg) speed_req_i = 2'(tgt2);
            if (fall < 0 && !clk_en_o) fall = cyc;
            if (sel_e < 0 && int'(clk_sel_o) != old) sel_e = cyc;
            if (fall >= 0 && clk_en_o) begin
               rise        = cyc;
               ack_at_rise = int'(speed_ack_o) + 2 * int'(ready_o);
               break;
            end
         end
         chk("sw_clk_en_fall", fall, s0);
         chk("sw_clk_sel_edge", sel_e, s0 + Q + 1);
         chk("sw_clk_sel_val", int'(clk_sel_o), fin);
         chk("sw_clk_en_rise", rise, s0 + 2 * Q + 1);
         chk("sw_ack_ready_at_rise", ack_at_rise, 3);
         tick();
         chk("sw_ack_count", ack_cnt - ack0, 1);
         model_sel = fin;
      end

      // Reserved request in RUN: nothing may move.
      speed_req_i = 2'b11;
      ack0   = ack_cnt;
      en_low = 0;
      repeat (30) begin
         tick();
         if (!clk_en_o || !ready_o) en_low++;
      end
      chk("rsv_en_drop", en_low, 0);
      chk("rsv_clk_sel", int'(clk_sel_o), model_sel);
      chk("rsv_no_ack", ack_cnt - ack0, 0);
      speed_req_i = 2'(model_sel);
      tick();

      // Loss of lock while in GATE_OFF.
      tgt  = (model_sel + 1) % 3;
      ack0 = ack_cnt;
      s0   = cyc + 1;
      speed_req_i = 2'(tgt);
      k = int'($urandom_range(3, Q));
      d = s0 + k - 3;
      tick_to(d);
      pll_locked_i = 1'b0;
      tick_to(d + 2);
      chk("loss_pre_pll_rst", int'(pll_rst_o), 0);
      chk("loss_pre_clk_en", int'(clk_en_o), 0);
      tick();
      chk("loss_pll_rst", int'(pll_rst_o), 1);
      chk("loss_clk_en", int'(clk_en_o), 0);
      chk("loss_ready", int'(ready_o), 0);
      chk("loss_clk_sel", int'(clk_sel_o), model_sel);
      wait_until(1, 1'b0, RST + 5, e);
      chk("loss_pll_rst_fall", e, d + 3 + RST);

      // Relock with reserved request pending and a 3-cycle glitch during STABLE.
      speed_req_i = 2'b11;
      repeat ($urandom_range(5, 60)) tick();
      big_e = cyc;
      pll_locked_i = 1'b1;
      g = big_e + 3 + int'($urandom_range(10, LS - 20));
      tick_to(g);
      chk("glitch_not_ready", int'(ready_o), 0);
      pll_locked_i = 1'b0;
      tick_to(g + 3);
      pll_locked_i = 1'b1;
      wait_until(0, 1'b1, LS + Q + 150, e);
      chk("glitch_ready_edge", e, g + 3 + 2 + LS + Q + 1);
      chk("relock_clk_sel_rsv", int'(clk_sel_o), 2);
      chk("loss_no_ack", ack_cnt - ack0, 0);
      model_sel = 2;

      // Reset mid-operation.
      repeat (5) tick();
      rst_i = 1'b1;
      tick();
      check_reset_outs("midrst");
      pll_locked_i = 1'b0;
      speed_req_i  = 2'b10;
      tick();
      rst_i = 1'b0;
      cyc   = 0;

      // Lock never arrives.
`ifdef ENET_PLL_SEQ_RETRY_EN
      for (int n = 1; n <= 3; n++) begin
         wait_until(3, 1'b1, RST + LT + 20, e);
         chk("retry_fault_edge", e, n * (RST + LT));
         chk("retry_cnt", int'(retry_cnt_o), n);
         chk("retry_pll_rst_high", int'(pll_rst_o), 1);
         tick();
         chk("retry_fault_pulse", int'(fault_o), 0);
         wait_until(1, 1'b0, RST + 5, e);
         chk("retry_pll_rst_fall", e, n * (RST + LT) + RST);
      end
`else
      wait_until(3, 1'b1, RST + LT + 20, e);
      chk("to_fault_edge", e, RST + LT);
      chk("to_retry_cnt", int'(retry_cnt_o), 1);
      chk("to_pll_rst", int'(pll_rst_o), 1);
      repeat (50) tick();
      chk("to_fault_sticky", int'(fault_o), 1);
      chk("to_retry_hold", int'(retry_cnt_o), 1);
      chk("to_pll_rst_hold", int'(pll_rst_o), 1);
      chk("to_clk_en", int'(clk_en_o), 0);
      rst_i = 1'b1;
      tick();
      chk("to_rst_fault", int'(fault_o), 0);
      chk("to_rst_retry", int'(retry_cnt_o), 0);
      rst_i = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
